// File: rtl/fpu_job_dispatcher.sv
// rtl/fpu_job_dispatcher.sv - descriptor FIFO and start/done issue FSM for the FPU (optional watchdog: FPU_JOB_TIMEOUT_EN)
module fpu_job_dispatcher #(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [5:0]                 job_op,
  input  logic [ADDR_W-1:0]          job_a,
  input  logic [ADDR_W-1:0]          job_b,
  input  logic [ADDR_W-1:0]          job_c,
  input  logic [ADDR_W-1:0]          job_d,
  output logic                       fpu_start,
  output logic [5:0]                 fpu_op,
  output logic [ADDR_W-1:0]          fpu_a,
  output logic [ADDR_W-1:0]          fpu_b,
  output logic [ADDR_W-1:0]          fpu_c,
  output logic [ADDR_W-1:0]          fpu_d,
  input  logic                       fpu_done,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [15:0]                jobs_retired,
  output logic                       err_bad_op,
  output logic                       err_timeout,
  input  logic                       clear_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [5:0] MAX_OP = 6'd17;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, state_nxt;

  logic [5:0]        op_mem [DEPTH];
  logic [ADDR_W-1:0] a_mem  [DEPTH];
  logic [ADDR_W-1:0] b_mem  [DEPTH];
  logic [ADDR_W-1:0] c_mem  [DEPTH];
  logic [ADDR_W-1:0] d_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  logic       push, pop, load_fpu, retire_inc, bad_op_set, timeout_hit;
  logic [5:0] head_op;

  assign job_ready = (fifo_count < FULL_CNT);
  assign push      = job_valid && job_ready;
  assign head_op   = op_mem[rd_ptr];
  assign busy      = (state != IDLE) || (fifo_count != '0);

  // descriptor storage; contents need no reset since count gates reads
  always_ff @(posedge clock) begin
    if (push) begin
      op_mem[wr_ptr] <= job_op;
      a_mem[wr_ptr]  <= job_a;
      b_mem[wr_ptr]  <= job_b;
      c_mem[wr_ptr]  <= job_c;
      d_mem[wr_ptr]  <= job_d;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // issue state register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state: NOOPs and bad opcodes are consumed in IDLE without issuing
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    load_fpu   = 1'b0;
    retire_inc = 1'b0;
    bad_op_set = 1'b0;
    fpu_start  = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop = 1'b1;
          if (head_op == 6'd0) begin
            retire_inc = 1'b1;
          end else if (head_op > MAX_OP) begin
            bad_op_set = 1'b1;
          end else begin
            load_fpu  = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        fpu_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (fpu_done) begin
          retire_inc = 1'b1;
          state_nxt  = IDLE;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operands presented to the FPU; held until the next issue
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fpu_op <= '0;
      fpu_a  <= '0;
      fpu_b  <= '0;
      fpu_c  <= '0;
      fpu_d  <= '0;
    end else if (load_fpu) begin
      fpu_op <= head_op;
      fpu_a  <= a_mem[rd_ptr];
      fpu_b  <= b_mem[rd_ptr];
      fpu_c  <= c_mem[rd_ptr];
      fpu_d  <= d_mem[rd_ptr];
    end
  end

  // completed-job counter, free-running wrap
  always_ff @(posedge clock) begin
    if (!reset_n)        jobs_retired <= '0;
    else if (retire_inc) jobs_retired <= jobs_retired + 16'd1;
  end

  // sticky bad-opcode flag; a fresh error beats a same-cycle clear
  always_ff @(posedge clock) begin
    if (!reset_n)        err_bad_op <= 1'b0;
    else if (bad_op_set) err_bad_op <= 1'b1;
    else if (clear_err)  err_bad_op <= 1'b0;
  end

`ifdef FPU_JOB_TIMEOUT_EN
  logic [31:0] wd_cnt;

  assign timeout_hit = (state == WAIT) && (wd_cnt == 32'(TIMEOUT_CYC - 1));

  // watchdog counts WAIT cycles, restarted while the start pulse is out
  always_ff @(posedge clock) begin
    if (!reset_n)            wd_cnt <= '0;
    else if (state == ISSUE) wd_cnt <= '0;
    else if (state == WAIT)  wd_cnt <= wd_cnt + 32'd1;
  end

  // sticky timeout flag; a fresh timeout beats a same-cycle clear
  always_ff @(posedge clock) begin
    if (!reset_n)         err_timeout <= 1'b0;
    else if (timeout_hit) err_timeout <= 1'b1;
    else if (clear_err)   err_timeout <= 1'b0;
  end
`else
  // no watchdog: WAIT only ends on fpu_done and the flag is constant 0
  assign timeout_hit = 1'b0;
  assign err_timeout = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_fpu_job_dispatcher.sv
// tb/tb_fpu_job_dispatcher.sv - scoreboard bench for fpu_job_dispatcher
module tb_fpu_job_dispatcher;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 16;
`ifdef FPU_JOB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 65535;
`endif

  logic              clock = 1'b0;
  logic              reset_n, job_valid, job_ready, fpu_start, fpu_done, busy;
  logic              err_bad_op, err_timeout, clear_err;
  logic [5:0]        job_op, fpu_op;
  logic [ADDR_W-1:0] job_a, job_b, job_c, job_d, fpu_a, fpu_b, fpu_c, fpu_d;
  logic [2:0]        fifo_count;
  logic [15:0]       jobs_retired;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int exp_retired = 0;
  logic [69:0] sb[$];
  logic [69:0] exp_job;
  bit got;
  bit acc;

  fpu_job_dispatcher #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset_n(reset_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_op(job_op), .job_a(job_a), .job_b(job_b), .job_c(job_c), .job_d(job_d),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_c(fpu_c), .fpu_d(fpu_d), .fpu_done(fpu_done), .busy(busy),
    .fifo_count(fifo_count), .jobs_retired(jobs_retired), .err_bad_op(err_bad_op),
    .err_timeout(err_timeout), .clear_err(clear_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (reset_n && fpu_start) start_cnt++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_job(input logic [5:0] op, input logic [15:0] a, b, c, d, output bit accepted);
    job_valid = 1'b1;
    job_op = op; job_a = a; job_b = b; job_c = c; job_d = d;
    accepted = job_ready;
    tick();
    job_valid = 1'b0;
    if (accepted && op != 6'd0 && op <= 6'd17) sb.push_back({op, a, b, c, d});
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (fpu_start) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic finish_job();
    tick();
    fpu_done = 1'b1;
    tick();
    fpu_done = 1'b0;
    exp_retired++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if ({job_ready, busy, fpu_start, err_bad_op, err_timeout} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b want 10000", {job_ready, busy, fpu_start, err_bad_op, err_timeout});
    end
    checks++;
    if (fifo_count !== 3'd0 || jobs_retired !== 16'd0 || fpu_op !== 6'd0 || fpu_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs got count=%0d retired=%0d op=%0d a=%h want 0", fifo_count, jobs_retired, fpu_op, fpu_a);
    end
  endtask

  task automatic test_single();
    push_job(6'd1, 16'h0010, 16'h0020, 16'h0030, 16'h0040, acc);
    checks++;
    if (fpu_start !== 1'b0 || fifo_count !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_after_push got start=%b count=%0d busy=%b want 0 1 1", fpu_start, fifo_count, busy);
    end
    tick();
    exp_job = sb.pop_front();
    checks++;
    if (fpu_start !== 1'b1 || {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== exp_job) begin
      errors++;
      $display("FAIL single_issue got start=%b job=%h want 1 %h", fpu_start, {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d}, exp_job);
    end
    repeat (3) begin
      tick();
      checks++;
      if (fpu_start !== 1'b0 || {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== exp_job) begin
        errors++;
        $display("FAIL single_hold got start=%b job=%h want 0 %h", fpu_start, {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d}, exp_job);
      end
    end
    fpu_done = 1'b1;
    tick();
    fpu_done = 1'b0;
    exp_retired++;
    checks++;
    if (jobs_retired !== 16'(exp_retired) || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done got retired=%0d busy=%b want %0d 0", jobs_retired, busy, exp_retired);
    end
  endtask

  task automatic test_fifo_full();
    int n_acc;
    int s0;
    n_acc = 0;
    s0 = start_cnt;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push_job(6'(2 + i), 16'(16'h100 + i), 16'(16'h200 + i), 16'(16'h300 + i), 16'(16'h400 + i), acc);
      if (acc) n_acc++;
    end
    checks++;
    if (n_acc !== DEPTH + 1 || job_ready !== 1'b0 || fifo_count !== 3'(DEPTH) || start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL fifo_fill got acc=%0d ready=%b count=%0d starts=%0d want %0d 0 %0d 1",
               n_acc, job_ready, fifo_count, start_cnt - s0, DEPTH + 1, DEPTH);
    end
    exp_job = sb.pop_front();
    checks++;
    if ({fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== exp_job) begin
      errors++;
      $display("FAIL fifo_first got %h want %h", {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d}, exp_job);
    end
    fpu_done = 1'b1;
    tick();
    fpu_done = 1'b0;
    exp_retired++;
    push_job(6'd7, 16'hdead, 16'hbeef, 16'h1111, 16'h2222, acc);
    checks++;
    if (acc !== 1'b0 || fifo_count !== 3'(DEPTH - 1)) begin
      errors++;
      $display("FAIL fifo_full_pop got acc=%b count=%0d want 0 %0d", acc, fifo_count, DEPTH - 1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      wait_start(got);
      exp_job = sb.pop_front();
      checks++;
      if (!got || {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== exp_job) begin
        errors++;
        $display("FAIL fifo_order[%0d] got seen=%b job=%h want %h", i, got, {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d}, exp_job);
      end
      finish_job();
    end
    checks++;
    if (jobs_retired !== 16'(exp_retired) || busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL fifo_drain got retired=%0d busy=%b left=%0d want %0d 0 0", jobs_retired, busy, sb.size(), exp_retired);
    end
  endtask

  task automatic test_noop();
    int s0;
    s0 = start_cnt;
    push_job(6'd0, 16'h0, 16'h0, 16'h0, 16'h0, acc);
    push_job(6'd5, 16'h0a0a, 16'h0b0b, 16'h0c0c, 16'h0d0d, acc);
    exp_retired++;
    checks++;
    if (jobs_retired !== 16'(exp_retired)) begin
      errors++;
      $display("FAIL noop_retire got %0d want %0d", jobs_retired, exp_retired);
    end
    wait_start(got);
    exp_job = sb.pop_front();
    checks++;
    if (!got || {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== exp_job) begin
      errors++;
      $display("FAIL noop_next got seen=%b job=%h want %h", got, {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d}, exp_job);
    end
    finish_job();
    checks++;
    if (jobs_retired !== 16'(exp_retired) || start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL noop_done got retired=%0d starts=%0d want %0d 1", jobs_retired, start_cnt - s0, exp_retired);
    end
  endtask

  task automatic test_bad_op();
    int s0;
    s0 = start_cnt;
    push_job(6'd40, 16'h1, 16'h2, 16'h3, 16'h4, acc);
    tick();
    checks++;
    if (err_bad_op !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_op_set got err=%b busy=%b want 1 0", err_bad_op, busy);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (err_bad_op !== 1'b0) begin
      errors++;
      $display("FAIL bad_op_clear got %b want 0", err_bad_op);
    end
    push_job(6'd18, 16'h5, 16'h6, 16'h7, 16'h8, acc);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (err_bad_op !== 1'b1) begin
      errors++;
      $display("FAIL bad_op_vs_clear got %b want 1", err_bad_op);
    end
    push_job(6'd17, 16'h1717, 16'h2727, 16'h3737, 16'h4747, acc);
    wait_start(got);
    exp_job = sb.pop_front();
    checks++;
    if (!got || {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== exp_job) begin
      errors++;
      $display("FAIL op17_issue got seen=%b job=%h want %h", got, {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d}, exp_job);
    end
    finish_job();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (start_cnt - s0 !== 1 || jobs_retired !== 16'(exp_retired) || err_bad_op !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL bad_op_end got starts=%0d retired=%0d err=%b to=%b want 1 %0d 0 0",
               start_cnt - s0, jobs_retired, err_bad_op, err_timeout, exp_retired);
    end
  endtask

  task automatic test_back_to_back();
    push_job(6'd8, 16'h8001, 16'h8002, 16'h8003, 16'h8004, acc);
    push_job(6'd9, 16'h9001, 16'h9002, 16'h9003, 16'h9004, acc);
    wait_start(got);
    exp_job = sb.pop_front();
    checks++;
    if (!got || {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== exp_job) begin
      errors++;
      $display("FAIL b2b_first got seen=%b job=%h want %h", got, {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d}, exp_job);
    end
    finish_job();
    checks++;
    if (fpu_start !== 1'b0 || jobs_retired !== 16'(exp_retired)) begin
      errors++;
      $display("FAIL b2b_gap got start=%b retired=%0d want 0 %0d", fpu_start, jobs_retired, exp_retired);
    end
    tick();
    exp_job = sb.pop_front();
    checks++;
    if (fpu_start !== 1'b1 || {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== exp_job) begin
      errors++;
      $display("FAIL b2b_second got start=%b job=%h want 1 %h", fpu_start, {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d}, exp_job);
    end
    finish_job();
    checks++;
    if (jobs_retired !== 16'(exp_retired) || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done got retired=%0d busy=%b want %0d 0", jobs_retired, busy, exp_retired);
    end
  endtask

`ifdef FPU_JOB_TIMEOUT_EN
  task automatic test_timeout();
    push_job(6'd10, 16'ha001, 16'ha002, 16'ha003, 16'ha004, acc);
    wait_start(got);
    exp_job = sb.pop_front();
    checks++;
    if (!got || {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== exp_job) begin
      errors++;
      $display("FAIL to_issue got seen=%b job=%h want %h", got, {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d}, exp_job);
    end
    repeat (TO) tick();
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_early got err=%b busy=%b want 0 1", err_timeout, busy);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || jobs_retired !== 16'(exp_retired)) begin
      errors++;
      $display("FAIL to_fire got err=%b busy=%b retired=%0d want 1 0 %0d", err_timeout, busy, jobs_retired, exp_retired);
    end
    fpu_done = 1'b1;
    tick();
    fpu_done = 1'b0;
    push_job(6'd11, 16'hb001, 16'hb002, 16'hb003, 16'hb004, acc);
    wait_start(got);
    exp_job = sb.pop_front();
    checks++;
    if (!got || {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== exp_job || jobs_retired !== 16'(exp_retired)) begin
      errors++;
      $display("FAIL to_next got seen=%b job=%h retired=%0d want %h %0d",
               got, {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d}, jobs_retired, exp_job, exp_retired);
    end
    finish_job();
    checks++;
    if (jobs_retired !== 16'(exp_retired) || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_after got retired=%0d err=%b want %0d 1", jobs_retired, err_timeout, exp_retired);
    end
  endtask
`endif

  task automatic test_reset_midjob();
    int s0;
    push_job(6'd3, 16'hc001, 16'hc002, 16'hc003, 16'hc004, acc);
    wait_start(got);
    exp_job = sb.pop_front();
    checks++;
    if (!got || {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== exp_job) begin
      errors++;
      $display("FAIL rst_issue got seen=%b job=%h want %h", got, {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d}, exp_job);
    end
    tick();
    for (int i = 0; i < 3; i++) push_job(6'(12 + i), 16'(i), 16'(i), 16'(i), 16'(i), acc);
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL rst_queued got %0d want 3", fifo_count);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sb.delete();
    exp_retired = 0;
    checks++;
    if (fifo_count !== 3'd0 || fpu_start !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b1 || jobs_retired !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid got count=%0d start=%b busy=%b ready=%b retired=%0d want 0 0 0 1 0",
               fifo_count, fpu_start, busy, job_ready, jobs_retired);
    end
    s0 = start_cnt;
    repeat (3) tick();
    fpu_done = 1'b1;
    tick();
    fpu_done = 1'b0;
    tick();
    checks++;
    if (jobs_retired !== 16'd0 || start_cnt - s0 !== 0) begin
      errors++;
      $display("FAIL rst_stray got retired=%0d starts=%0d want 0 0", jobs_retired, start_cnt - s0);
    end
  endtask

  initial begin
    reset_n = 1'b0; job_valid = 1'b0; fpu_done = 1'b0; clear_err = 1'b0;
    job_op = '0; job_a = '0; job_b = '0; job_c = '0; job_d = '0;
    test_reset();
    test_single();
    test_fifo_full();
    test_noop();
    test_bad_op();
    test_back_to_back();
`ifdef FPU_JOB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midjob();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
